// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator.
// Also keeps counts of condition evaluations and taken results.
module cc_cond_unit #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CND_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cc_in,
    input  logic             set_cc,
    input  logic             stall,
    input  logic             exc,
    input  logic             cond_valid,
    input  logic [3:0]       ifun,
    input  logic             cnt_clr,
    output logic [2:0]       cc_q,
    output logic             cnd,
    output logic             cnd_valid,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Flag bit positions within the 3-bit CC word: {ZF, SF, OF}.
    localparam int unsigned ZF_BIT = 2;
    localparam int unsigned SF_BIT = 1;
    localparam int unsigned OF_BIT = 0;
    localparam logic [2:0]  CC_RST = 3'b100;

    localparam logic [3:0] FN_ALWAYS = 4'd0;
    localparam logic [3:0] FN_LE     = 4'd1;
    localparam logic [3:0] FN_L      = 4'd2;
    localparam logic [3:0] FN_E      = 4'd3;
    localparam logic [3:0] FN_NE     = 4'd4;
    localparam logic [3:0] FN_GE     = 4'd5;
    localparam logic [3:0] FN_G      = 4'd6;

    logic [2:0]       cc_d;
    logic             zf_c;
    logic             lt_c;
    logic             fn_c;
    logic             cnd_now_c;
    logic             count_en_c;
    logic [CNT_W-1:0] eval_cnt_q;
    logic [CNT_W-1:0] eval_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;

    // CC load; an excepting or stalled instruction must not change the flags.
    always_comb begin
        cc_d = cc_q;
        if (set_cc && !stall && !exc) begin
            cc_d = cc_in;
        end
    end

    // Condition function evaluated against the stored flags only.
    always_comb begin
        zf_c = cc_q[ZF_BIT];
        lt_c = cc_q[SF_BIT] ^ cc_q[OF_BIT];
        fn_c = 1'b0;
        case (ifun)
            FN_ALWAYS: fn_c = 1'b1;
            FN_LE:     fn_c = lt_c | zf_c;
            FN_L:      fn_c = lt_c;
            FN_E:      fn_c = zf_c;
            FN_NE:     fn_c = ~zf_c;
            FN_GE:     fn_c = ~lt_c;
            FN_G:      fn_c = ~lt_c & ~zf_c;
            default:   fn_c = 1'b0;
        endcase
        cnd_now_c = cond_valid & fn_c;
    end

    // Statistics counters; stall beats clear, clear beats increment.
    always_comb begin
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;
        count_en_c  = cond_valid & ~exc;
        if (!stall) begin
            if (cnt_clr) begin
                eval_cnt_d  = '0;
                taken_cnt_d = '0;
            end else if (count_en_c) begin
                eval_cnt_d = eval_cnt_q + CNT_W'(1);
                if (cnd_now_c) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q        <= CC_RST;
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            cc_q        <= cc_d;
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;

    generate
        if (CND_REG != 0) begin : g_cnd_reg
            logic cnd_q;
            logic cnd_d;
            logic cnd_valid_q;
            logic cnd_valid_d;

            always_comb begin
                cnd_d       = cnd_q;
                cnd_valid_d = cnd_valid_q;
                if (!stall) begin
                    cnd_d       = cnd_now_c;
                    cnd_valid_d = cond_valid & ~exc;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnd_q       <= 1'b0;
                    cnd_valid_q <= 1'b0;
                end else begin
                    cnd_q       <= cnd_d;
                    cnd_valid_q <= cnd_valid_d;
                end
            end

            assign cnd       = cnd_q;
            assign cnd_valid = cnd_valid_q;
        end else begin : g_cnd_comb
            assign cnd       = cnd_now_c;
            assign cnd_valid = cond_valid;
        end
    endgenerate

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: default, 4-bit-counter and registered-cnd instances share stimulus.
module tb_cc_cond_unit;

    logic       clk;
    logic       reset;
    logic [2:0] cc_in;
    logic       set_cc;
    logic       stall;
    logic       exc;
    logic       cond_valid;
    logic [3:0] ifun;
    logic       cnt_clr;

    logic [2:0]  cc0, ccw, ccr;
    logic        cnd0, cndw, cndr;
    logic        cv0, cvw, cvr;
    logic [31:0] ev0, tk0, evr, tkr;
    logic [3:0]  evw, tkw;

    int n_checks = 0;
    int n_fail   = 0;

    cc_cond_unit u0 (
        .clk(clk), .reset(reset), .cc_in(cc_in), .set_cc(set_cc), .stall(stall),
        .exc(exc), .cond_valid(cond_valid), .ifun(ifun), .cnt_clr(cnt_clr),
        .cc_q(cc0), .cnd(cnd0), .cnd_valid(cv0), .eval_cnt(ev0), .taken_cnt(tk0)
    );

    cc_cond_unit #(.CNT_W(4)) u_w (
        .clk(clk), .reset(reset), .cc_in(cc_in), .set_cc(set_cc), .stall(stall),
        .exc(exc), .cond_valid(cond_valid), .ifun(ifun), .cnt_clr(cnt_clr),
        .cc_q(ccw), .cnd(cndw), .cnd_valid(cvw), .eval_cnt(evw), .taken_cnt(tkw)
    );

    cc_cond_unit #(.CND_REG(1)) u_r (
        .clk(clk), .reset(reset), .cc_in(cc_in), .set_cc(set_cc), .stall(stall),
        .exc(exc), .cond_valid(cond_valid), .ifun(ifun), .cnt_clr(cnt_clr),
        .cc_q(ccr), .cnd(cndr), .cnd_valid(cvr), .eval_cnt(evr), .taken_cnt(tkr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cc_in = 3'b000; set_cc = 1'b0; stall = 1'b0; exc = 1'b0;
        cond_valid = 1'b0; ifun = 4'd0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // Load SF|OF and bump the counters, then reset mid-cycle.
        cc_in = 3'b011; set_cc = 1'b1;
        tick();
        set_cc = 1'b0; cond_valid = 1'b1; ifun = 4'd0;
        tick();
        cond_valid = 1'b0;
        n_checks++;
        if (cc0 !== 3'b011) begin n_fail++; $display("FAIL pre_reset_cc got %b exp %b", cc0, 3'b011); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cc0 !== 3'b100) begin n_fail++; $display("FAIL reset_cc got %b exp %b", cc0, 3'b100); end
        n_checks++;
        if (ev0 !== 32'd0 || tk0 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", ev0, tk0); end
        n_checks++;
        if (cndr !== 1'b0 || cvr !== 1'b0) begin n_fail++; $display("FAIL reset_cndreg got %b/%b exp 0/0", cndr, cvr); end
        #2;
        reset = 1'b0;
        cond_valid = 1'b1; ifun = 4'd3;
        #1;
        n_checks++;
        if (cnd0 !== 1'b1) begin n_fail++; $display("FAIL reset_e got %b exp 1", cnd0); end
        ifun = 4'd4;
        #1;
        n_checks++;
        if (cnd0 !== 1'b0) begin n_fail++; $display("FAIL reset_ne got %b exp 0", cnd0); end
        cond_valid = 1'b0;
        #1;
        n_checks++;
        if (cnd0 !== 1'b0 || cv0 !== 1'b0) begin n_fail++; $display("FAIL idle_cnd got %b/%b exp 0/0", cnd0, cv0); end
    endtask

    task automatic test_cond_matrix();
        // Expected cnd for ifun 0..7, bit i = ifun i, indexed by {ZF,SF,OF}.
        logic [7:0] tbl [8];
        logic       exp_b;
        tbl[0] = 8'h71; tbl[1] = 8'h17; tbl[2] = 8'h17; tbl[3] = 8'h71;
        tbl[4] = 8'h2B; tbl[5] = 8'h0F; tbl[6] = 8'h0F; tbl[7] = 8'h2B;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            cc_in = 3'(c); set_cc = 1'b1;
            tick();
            set_cc = 1'b0;
            n_checks++;
            if (cc0 !== 3'(c)) begin n_fail++; $display("FAIL matrix_load c=%0d got %b exp %b", c, cc0, 3'(c)); end
            for (int i = 0; i < 16; i++) begin
                cond_valid = 1'b1; ifun = 4'(i);
                #1;
                exp_b = (i < 8) ? tbl[c][i] : 1'b0;
                n_checks++;
                if (cnd0 !== exp_b || cv0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL matrix cc=%b ifun=%0d got %b/%b exp %b/1", 3'(c), i, cnd0, cv0, exp_b);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_gating();
        do_reset();
        cc_in = 3'b011; set_cc = 1'b1; stall = 1'b1;
        tick();
        n_checks++;
        if (cc0 !== 3'b100) begin n_fail++; $display("FAIL gate_stall got %b exp %b", cc0, 3'b100); end
        stall = 1'b0; exc = 1'b1;
        tick();
        n_checks++;
        if (cc0 !== 3'b100) begin n_fail++; $display("FAIL gate_exc got %b exp %b", cc0, 3'b100); end
        exc = 1'b0; cc_in = 3'b001;
        tick();
        n_checks++;
        if (cc0 !== 3'b001) begin n_fail++; $display("FAIL gate_load_of got %b exp %b", cc0, 3'b001); end
        cc_in = 3'b100;
        tick();
        n_checks++;
        if (cc0 !== 3'b100) begin n_fail++; $display("FAIL gate_load_zf got %b exp %b", cc0, 3'b100); end
        // Load and evaluate together: evaluation sees the old ZF=1.
        cc_in = 3'b000; cond_valid = 1'b1; ifun = 4'd3;
        #1;
        n_checks++;
        if (cnd0 !== 1'b1) begin n_fail++; $display("FAIL same_cycle_cnd got %b exp 1", cnd0); end
        tick();
        set_cc = 1'b0;
        n_checks++;
        if (cc0 !== 3'b000) begin n_fail++; $display("FAIL same_cycle_cc got %b exp %b", cc0, 3'b000); end
        n_checks++;
        if (cndr !== 1'b1) begin n_fail++; $display("FAIL same_cycle_reg got %b exp 1", cndr); end
        n_checks++;
        if (cnd0 !== 1'b0) begin n_fail++; $display("FAIL after_load_e got %b exp 0", cnd0); end
        idle_inputs();
    endtask

    task automatic test_counters();
        do_reset();
        cond_valid = 1'b1;
        ifun = 4'd3; tick();                 // taken
        ifun = 4'd0; tick();                 // taken
        ifun = 4'd4; tick();                 // untaken
        ifun = 4'd3; exc = 1'b1; tick();     // taken, excluded by exc
        n_checks++;
        if (cvr !== 1'b0 || cndr !== 1'b1) begin n_fail++; $display("FAIL exc_cndreg got %b/%b exp 0/1", cvr, cndr); end
        exc = 1'b0; ifun = 4'd4; stall = 1'b1; tick();   // untaken, excluded by stall
        stall = 1'b0; cond_valid = 1'b0; tick();
        n_checks++;
        if (ev0 !== 32'd3 || tk0 !== 32'd2) begin n_fail++; $display("FAIL count got %0d/%0d exp 3/2", ev0, tk0); end
        cnt_clr = 1'b1; stall = 1'b1; tick();
        n_checks++;
        if (ev0 !== 32'd3 || tk0 !== 32'd2) begin n_fail++; $display("FAIL clr_stall got %0d/%0d exp 3/2", ev0, tk0); end
        stall = 1'b0; cond_valid = 1'b1; ifun = 4'd0; tick();
        n_checks++;
        if (ev0 !== 32'd0 || tk0 !== 32'd0) begin n_fail++; $display("FAIL clr_prio got %0d/%0d exp 0/0", ev0, tk0); end
        cnt_clr = 1'b0; tick();
        n_checks++;
        if (ev0 !== 32'd1 || tk0 !== 32'd1) begin n_fail++; $display("FAIL post_clr got %0d/%0d exp 1/1", ev0, tk0); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        cond_valid = 1'b1; ifun = 4'd0;
        for (int k = 0; k < 17; k++) tick();
        cond_valid = 1'b0;
        n_checks++;
        if (evw !== 4'd1 || tkw !== 4'd1) begin n_fail++; $display("FAIL wrap4 got %0d/%0d exp 1/1", evw, tkw); end
        n_checks++;
        if (ev0 !== 32'd17 || tk0 !== 32'd17) begin n_fail++; $display("FAIL nowrap32 got %0d/%0d exp 17/17", ev0, tk0); end
    endtask

    task automatic test_cnd_reg();
        do_reset();
        cond_valid = 1'b1; ifun = 4'd0;
        #1;
        n_checks++;
        if (cndr !== 1'b0 || cvr !== 1'b0) begin n_fail++; $display("FAIL reg_latency got %b/%b exp 0/0", cndr, cvr); end
        tick();
        n_checks++;
        if (cndr !== 1'b1 || cvr !== 1'b1) begin n_fail++; $display("FAIL reg_n1 got %b/%b exp 1/1", cndr, cvr); end
        cond_valid = 1'b0; stall = 1'b1;
        tick();
        n_checks++;
        if (cndr !== 1'b1 || cvr !== 1'b1) begin n_fail++; $display("FAIL reg_stall got %b/%b exp 1/1", cndr, cvr); end
        stall = 1'b0;
        tick();
        n_checks++;
        if (cndr !== 1'b0 || cvr !== 1'b0) begin n_fail++; $display("FAIL reg_release got %b/%b exp 0/0", cndr, cvr); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // Load flags each cycle and evaluate the previous value with registered cnd.
        do_reset();
        cc_in = 3'b010; set_cc = 1'b1; cond_valid = 1'b1; ifun = 4'd2;
        tick();
        n_checks++;
        if (cndr !== 1'b0) begin n_fail++; $display("FAIL b2b_first got %b exp 0", cndr); end
        cc_in = 3'b000;
        tick();
        n_checks++;
        if (cndr !== 1'b1 || cc0 !== 3'b000) begin n_fail++; $display("FAIL b2b_second got %b/%b exp 1/000", cndr, cc0); end
        idle_inputs();
        tick();
        n_checks++;
        if (ev0 !== 32'd2 || tk0 !== 32'd1) begin n_fail++; $display("FAIL b2b_cnt got %0d/%0d exp 2/1", ev0, tk0); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_cond_matrix();
        test_gating();
        test_counters();
        test_wrap();
        test_cnd_reg();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
- Consumer end of the ALU flag interface in the sequential Y86-64 CPU.
- Holds the architectural condition-code register (ZF/SF/OF), loaded from the ALU's 3-bit flag output at the end of execute for OPq instructions.
- Evaluates jXX/cmovXX conditions against the stored flags to produce Cnd for the PC-update and writeback paths.
- Keeps per-run branch statistics: evaluations and taken count.

Parameters:
- CNT_W, 32, width of the evaluation and taken-branch counters.
- CND_REG, 0, 0 = cnd is combinational from the current CC; 1 = cnd is registered with one cycle of latency.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cc_in  input  3  flags from the ALU; bit positions are the shared ZF/SF/OF constants in cpu_definitions.v.
- set_cc  input  1  load request; high for OPq in the execute stage.
- stall  input  1  freezes all state (CC, counters, registered cnd).
- exc  input  1  current instruction has a non-AOK status; blocks the CC load and the count increments.
- cond_valid  input  1  the current instruction is jXX or cmovXX and ifun is to be evaluated.
- ifun  input  4  condition function code.
- cnt_clr  input  1  synchronous clear of both counters.
- cc_q  output  3  current condition-code register.
- cnd  output  1  condition result.
- cnd_valid  output  1  qualifies cnd; only meaningful when CND_REG=1, and tied to cond_valid when CND_REG=0.
- eval_cnt  output  CNT_W  number of condition evaluations.
- taken_cnt  output  CNT_W  number of evaluations with result 1.

Behaviour:
- Reset, asynchronous and active-high:
  - cc_q = ZF=1, SF=0, OF=0 (Y86 architectural reset state).
  - cnd=0, cnd_valid=0, eval_cnt=0, taken_cnt=0.
  - Reset mid-operation discards any pending load or registered result.
- CC load: on a rising edge with set_cc & ~stall & ~exc, cc_q <= cc_in. Otherwise cc_q holds.
- Condition function, with s = SF^OF (computed from cc_q, never from cc_in):
  - 0 always: 1.
  - 1 le: s|ZF.
  - 2 l: s.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~s.
  - 6 g: ~s & ~ZF.
  - 7..15: 0, and treated as a counted evaluation only when exc=0.
- Same-cycle ordering: with set_cc and cond_valid both high, evaluation uses the old cc_q. This matches SEQ, where OPq never branches in the same instruction.
- CND_REG=0:
  - cnd = f(ifun, cc_q) when cond_valid, else 0.
  - cnd_valid = cond_valid.
- CND_REG=1:
  - On an edge with ~stall: cnd <= (cond_valid ? f : 0) and cnd_valid <= cond_valid & ~exc.
  - On a stall edge: both hold.
- Counters:
  - Update on an edge with cond_valid & ~stall & ~exc: eval_cnt += 1, and taken_cnt += 1 if the result is 1.
  - Both wrap modulo 2^CNT_W with no saturation.
  - cnt_clr has priority over an increment in the same cycle; after that edge both counters read 0.
  - stall has priority over cnt_clr: clear only when ~stall.
- Flags are stored exactly as delivered, with no recomputation. cc_in must be stable at the edge.

Test Plan:
- Reset check: assert reset mid-run with cc_q=SF|OF → cc_q immediately ZF=1/SF=0/OF=0, counters 0. After release, cond_valid ifun=3 → cnd=1, ifun=4 → cnd=0.
- Condition matrix: load each of the 8 flag combinations via set_cc, then evaluate ifun 0..7 → cnd matches the table. Example: SF=1,OF=0,ZF=0 gives le=1, l=1, e=0, ne=1, ge=0, g=0, ifun7=0.
- Gating:
  - set_cc with stall=1 → cc_q unchanged.
  - set_cc with exc=1 → unchanged.
  - set_cc with both low → loads cc_in=ZF only, cc_q=ZF.
  - Simultaneous set_cc(cc_in=0) and cond_valid ifun=3 with old ZF=1 → cnd=1, then cc_q=0.
- Counters: 5 evaluations, 3 taken, 1 with exc=1, 1 during stall → eval_cnt=3, taken_cnt=2 (excluded ones: exc taken, stall untaken). cnt_clr with a taken eval in the same cycle → both 0.
- Wrap: CNT_W=4, 17 taken evaluations → eval_cnt=1, taken_cnt=1.
- CND_REG=1: cond_valid ifun=0 at cycle n → cnd=1, cnd_valid=1 at n+1. A stall at n+1 holds both values at n+2.
